// File: rtl/uart_host_pkg.sv
// Shared types and helpers for the UART regfile host: FSM states, response
// status codes, packet geometry and the odd-parity helper.
package uart_host_pkg;

  localparam int   PKT_W = 18;
  localparam logic WRITE = 1'b0;
  localparam logic READ  = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    RX_WAIT,
    RX_START,
    RX_DATA,
    RX_STOP,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    ST_OK      = 3'd0,
    ST_PARITY  = 3'd1,
    ST_ADDR    = 3'd2,
    ST_FRAME   = 3'd3,
    ST_TIMEOUT = 3'd4
  } status_e;

  // Bit that makes the total number of ones across {bit, v} odd.
  function automatic logic odd_parity(input logic [PKT_W-2:0] v);
    return ~(^v);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period divider shared by the TX and RX paths; restart realigns the
// period so mid_tick/bit_tick land relative to the restart cycle.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic mid_tick,
  output logic bit_tick
);

  localparam int             CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_r;

  // Free-running modulo-CLKS_PER_BIT counter, zeroed on restart.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt_r <= CW'(0);
    end else if (cnt_r == LAST) begin
      cnt_r <= CW'(0);
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign mid_tick = (cnt_r == MID);
  assign bit_tick = (cnt_r == LAST);

endmodule

// File: rtl/uart_regfile_host.sv
// FPGA-side initiator for the UART regfile link: sends an 18-bit command
// packet on posi and, for reads, receives and checks the reply on piso.
// Optional read-reply timeout: define UART_HOST_TIMEOUT_EN.
module uart_regfile_host
  import uart_host_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_wrb,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic [2:0] rsp_status,
  output logic       posi,
  input  logic       piso
);

  localparam int              TO_W     = $clog2(TIMEOUT_BITS + 1);
  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_BITS);
  localparam logic [4:0]      LAST_BIT = 5'(PKT_W - 1);

  state_e          state_r, state_nxt;
  logic            mid_tick_s, bit_tick_s, restart_s, accept_s, fall_s, timeout_hit_s;
  logic            piso_meta_r, piso_sync_r, piso_prev_r;
  logic            wrb_r;
  logic [7:0]      addr_r;
  logic [PKT_W-1:0] tx_sh_r, rx_sh_r;
  logic [4:0]      bit_cnt_r;
  logic [TO_W-1:0] to_cnt_r;
  logic            fin_load_s;
  status_e         fin_status_s, res_status_r;
  logic [7:0]      fin_data_s, res_data_r;
  logic            cmd_ready_r, rsp_valid_r, posi_r;
  logic [7:0]      rsp_data_r;
  logic [2:0]      rsp_status_r;
  logic [PKT_W-2:0] body_s;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart_s),
    .mid_tick (mid_tick_s),
    .bit_tick (bit_tick_s)
  );

  assign accept_s = cmd_valid && cmd_ready_r;
  assign fall_s   = piso_prev_r && !piso_sync_r;
  // Data field is ignored on reads, so it goes out as zero.
  assign body_s   = {cmd_addr, (cmd_wrb == READ) ? 8'h00 : cmd_data, cmd_wrb};

`ifdef UART_HOST_TIMEOUT_EN
  assign timeout_hit_s = bit_tick_s && (to_cnt_r == TO_W'(TIMEOUT_BITS - 1));
`else
  assign timeout_hit_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt;
  end

  // Next state, timer restarts and the completion status/data.
  always_comb begin
    state_nxt    = state_r;
    restart_s    = 1'b0;
    fin_load_s   = 1'b0;
    fin_status_s = ST_OK;
    fin_data_s   = 8'h00;
    case (state_r)
      IDLE: begin
        restart_s = 1'b1;
        if (accept_s) state_nxt = TX_START;
        else          state_nxt = IDLE;
      end
      TX_START: begin
        if (bit_tick_s) state_nxt = TX_DATA;
        else            state_nxt = TX_START;
      end
      TX_DATA: begin
        if (bit_tick_s && bit_cnt_r == LAST_BIT) state_nxt = TX_STOP;
        else                                     state_nxt = TX_DATA;
      end
      TX_STOP: begin
        if (bit_tick_s && wrb_r == READ) begin
          state_nxt = RX_WAIT;
        end else if (bit_tick_s) begin
          state_nxt  = DONE;
          fin_load_s = 1'b1;
        end else begin
          state_nxt = TX_STOP;
        end
      end
      RX_WAIT: begin
        if (fall_s) begin
          state_nxt = RX_START;
          restart_s = 1'b1;
        end else if (timeout_hit_s) begin
          state_nxt    = DONE;
          fin_load_s   = 1'b1;
          fin_status_s = ST_TIMEOUT;
        end else begin
          state_nxt = RX_WAIT;
        end
      end
      RX_START: begin
        // A line already back high at mid-bit was a glitch, not a start bit.
        if (mid_tick_s && piso_sync_r) begin
          state_nxt = RX_WAIT;
        end else if (mid_tick_s) begin
          state_nxt = RX_DATA;
          restart_s = 1'b1;
        end else begin
          state_nxt = RX_START;
        end
      end
      RX_DATA: begin
        if (bit_tick_s && bit_cnt_r == LAST_BIT) state_nxt = RX_STOP;
        else                                     state_nxt = RX_DATA;
      end
      RX_STOP: begin
        if (bit_tick_s) begin
          state_nxt  = DONE;
          fin_load_s = 1'b1;
          fin_data_s = rx_sh_r[8:1];
          if (!piso_sync_r)                                         fin_status_s = ST_FRAME;
          else if (rx_sh_r[PKT_W-1] != odd_parity(rx_sh_r[PKT_W-2:0])) fin_status_s = ST_PARITY;
          else if (rx_sh_r[16:9] != addr_r)                         fin_status_s = ST_ADDR;
          else                                                      fin_status_s = ST_OK;
        end else begin
          state_nxt = RX_STOP;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // piso synchroniser plus one extra stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      piso_meta_r <= 1'b1;
      piso_sync_r <= 1'b1;
      piso_prev_r <= 1'b1;
    end else begin
      piso_meta_r <= piso;
      piso_sync_r <= piso_meta_r;
      piso_prev_r <= piso_sync_r;
    end
  end

  // Command latch, TX shifter/line driver and RX shifter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrb_r     <= WRITE;
      addr_r    <= 8'h00;
      tx_sh_r   <= {PKT_W{1'b1}};
      rx_sh_r   <= {PKT_W{1'b0}};
      bit_cnt_r <= 5'd0;
      posi_r    <= 1'b1;
    end else if (accept_s) begin
      wrb_r     <= cmd_wrb;
      addr_r    <= cmd_addr;
      tx_sh_r   <= {odd_parity(body_s), body_s};
      bit_cnt_r <= 5'd0;
      posi_r    <= 1'b0;
    end else if (state_r == TX_START && bit_tick_s) begin
      posi_r <= tx_sh_r[0];
    end else if (state_r == TX_DATA && bit_tick_s) begin
      posi_r    <= (bit_cnt_r == LAST_BIT) ? 1'b1 : tx_sh_r[1];
      tx_sh_r   <= {1'b1, tx_sh_r[PKT_W-1:1]};
      bit_cnt_r <= (bit_cnt_r == LAST_BIT) ? 5'd0 : bit_cnt_r + 5'd1;
    end else if (state_r == RX_START && mid_tick_s) begin
      bit_cnt_r <= 5'd0;
    end else if (state_r == RX_DATA && bit_tick_s) begin
      rx_sh_r   <= {piso_sync_r, rx_sh_r[PKT_W-1:1]};
      bit_cnt_r <= bit_cnt_r + 5'd1;
    end
  end

  // Reply-wait bit-period counter; saturates so it never wraps.
  always_ff @(posedge clk) begin
    if (reset || state_r == TX_STOP) begin
      to_cnt_r <= TO_W'(0);
    end else if (state_r == RX_WAIT && bit_tick_s && to_cnt_r != TO_MAX) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end
  end

  // Handshake and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_ready_r  <= 1'b1;
      rsp_valid_r  <= 1'b0;
      rsp_data_r   <= 8'h00;
      rsp_status_r <= 3'd0;
      res_data_r   <= 8'h00;
      res_status_r <= ST_OK;
    end else begin
      if (fin_load_s) begin
        res_data_r   <= fin_data_s;
        res_status_r <= fin_status_s;
      end
      if (state_r == DONE) begin
        rsp_valid_r  <= 1'b1;
        rsp_data_r   <= res_data_r;
        rsp_status_r <= res_status_r;
      end else begin
        rsp_valid_r <= 1'b0;
      end
      if (accept_s)         cmd_ready_r <= 1'b0;
      else if (rsp_valid_r) cmd_ready_r <= 1'b1;
    end
  end

  assign cmd_ready  = cmd_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;
  assign rsp_status = rsp_status_r;
  assign posi       = posi_r;

endmodule

// File: tb/tb_uart_regfile_host.sv
// Self-checking bench for uart_regfile_host: decodes the posi frame, plays the
// chip side on piso from a regfile model, and scores every response.
module tb_uart_regfile_host;

  localparam int CPB = 16;
  localparam int TOB = 64;
  localparam int PER = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_wrb = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_data = 8'h00;
  logic       piso = 1'b1;
  logic       cmd_ready, rsp_valid, posi;
  logic [7:0] rsp_data;
  logic [2:0] rsp_status;

  int checks = 0;
  int errors = 0;
  logic [7:0] mem [256];

  always #(PER/2) clk = ~clk;

  uart_regfile_host #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wrb(cmd_wrb), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .posi(posi), .piso(piso)
  );

  // Packet per the wire format: odd total ones count over all 18 bits.
  function automatic logic [17:0] model_pkt(input logic wrb, input logic [7:0] addr, input logic [7:0] data);
    logic [16:0] body;
    body = {addr, data, wrb};
    return {(($countones(body) % 2) == 0) ? 1'b1 : 1'b0, body};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; cmd_valid = 1'b0; piso = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Issue a command and decode the frame it produces on posi.
  task automatic send_cmd(input logic wrb, input logic [7:0] addr, input logic [7:0] data,
                          output logic [17:0] pkt, output logic frame_ok, output time t_acc);
    int w;
    w = 0; pkt = '0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_wait got %b want 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_wrb = wrb; cmd_addr = addr; cmd_data = data;
    @(posedge clk);
    t_acc = $time;
    #1 cmd_valid = 1'b0;
    #(CPB/2*PER + 4);
    frame_ok = (posi === 1'b0);
    for (int i = 0; i < 18; i++) begin #(CPB*PER); pkt[i] = posi; end
    #(CPB*PER);
    frame_ok = frame_ok && (posi === 1'b1);
  endtask

  task automatic wait_rsp(input int max_cyc, input time t_ref, output logic got, output logic [7:0] d,
                          output logic [2:0] st, output int lat, output logic rdy);
    got = 1'b0; d = 8'h00; st = 3'd0; lat = -1; rdy = 1'b0;
    for (int c = 0; c < max_cyc && !got; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        got = 1'b1; d = rsp_data; st = rsp_status; lat = int'(($time - t_ref) / PER);
      end
    end
    if (got) begin @(negedge clk); rdy = cmd_ready; end
  endtask

  // Drive one reply frame on piso while watching for the response pulse.
  task automatic send_reply(input logic [17:0] pkt, input logic stop_v, output logic got,
                            output logic [7:0] d, output logic [2:0] st, output int lat, output logic rdy);
    time t0;
    logic pend;
    got = 1'b0; d = 8'h00; st = 3'd0; lat = -1; rdy = 1'b0; pend = 1'b0; t0 = 0;
    for (int b = 0; b < 20 + 4; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (c == 0) begin
          piso = (b == 0) ? 1'b0 : (b == 19) ? stop_v : (b > 19) ? 1'b1 : pkt[b-1];
          if (b == 0) t0 = $time;
        end
        if (pend) begin rdy = cmd_ready; pend = 1'b0; end
        if (rsp_valid === 1'b1 && !got) begin
          got = 1'b1; d = rsp_data; st = rsp_status; lat = int'(($time - t0) / PER); pend = 1'b1;
        end
      end
    end
    piso = 1'b1;
  endtask

  // One full read: request, chip reply, response; checks request and response.
  task automatic do_read(input string nm, input logic [7:0] addr, input logic [17:0] reply,
                         input logic stop_v, input logic [2:0] exp_st, input logic [7:0] exp_d);
    logic [17:0] pkt; logic fok, got, rdy; logic [7:0] d; logic [2:0] st; int lat; time ta;
    send_cmd(1'b1, addr, $urandom, pkt, fok, ta);
    checks++;
    if (pkt !== model_pkt(1'b1, addr, 8'h00) || !fok) begin
      errors++; $display("FAIL %s_req pkt %h frame %b want %h frame 1", nm, pkt, fok, model_pkt(1'b1, addr, 8'h00));
    end
    #(CPB/2*PER);
    repeat ($urandom_range(1, 6)) @(negedge clk);
    send_reply(reply, stop_v, got, d, st, lat, rdy);
    checks++;
    if (!got || st !== exp_st || rdy !== 1'b1) begin
      errors++; $display("FAIL %s_rsp got %b status %0d ready %b want 1 %0d 1", nm, got, st, rdy, exp_st);
    end
    if (exp_st == 3'd0) begin
      checks++;
      if (d !== exp_d) begin errors++; $display("FAIL %s_data got %h want %h", nm, d, exp_d); end
    end
    checks++;
    if (lat < 19*CPB + CPB/2 || lat > 20*CPB) begin
      errors++; $display("FAIL %s_latency got %0d want %0d..%0d", nm, lat, 19*CPB + CPB/2, 20*CPB);
    end
  endtask

  task automatic do_write(input string nm, input logic [7:0] addr, input logic [7:0] data, input logic chk_lat);
    logic [17:0] pkt; logic fok, got, rdy; logic [7:0] d; logic [2:0] st; int lat; time ta;
    send_cmd(1'b0, addr, data, pkt, fok, ta);
    checks++;
    if (pkt !== model_pkt(1'b0, addr, data) || !fok) begin
      errors++; $display("FAIL %s_pkt got %h frame %b want %h frame 1", nm, pkt, fok, model_pkt(1'b0, addr, data));
    end
    wait_rsp(4*CPB, ta, got, d, st, lat, rdy);
    checks++;
    if (!got || st !== 3'd0 || d !== 8'h00 || rdy !== 1'b1) begin
      errors++; $display("FAIL %s_rsp got %b status %0d data %h ready %b want 1 0 00 1", nm, got, st, d, rdy);
    end
    if (chk_lat) begin
      checks++;
      if (lat !== 20*CPB + 1) begin errors++; $display("FAIL %s_latency got %0d want %0d", nm, lat, 20*CPB + 1); end
    end
    mem[addr] = data;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (posi !== 1'b1)      begin errors++; $display("FAIL reset_posi got %b want 1", posi); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got %h want 00", rsp_data); end
    checks++; if (rsp_status !== 3'd0) begin errors++; $display("FAIL reset_status got %0d want 0", rsp_status); end
  endtask

  task automatic test_write();
    do_write("write01", 8'h01, 8'hAB, 1'b1);
    do_write("write7f", 8'h7F, 8'h00, 1'b1);
  endtask

  task automatic test_read();
    do_read("read01", 8'h01, model_pkt(1'b1, 8'h01, mem[8'h01]), 1'b1, 3'd0, mem[8'h01]);
  endtask

  task automatic test_errors();
    do_read("parity", 8'h01, model_pkt(1'b1, 8'h01, 8'hAB) ^ 18'h20000, 1'b1, 3'd1, 8'h00);
    do_read("addr", 8'h01, model_pkt(1'b1, 8'h02, 8'hAB), 1'b1, 3'd2, 8'h00);
    do_read("frame", 8'h01, model_pkt(1'b1, 8'h01, 8'hAB), 1'b0, 3'd3, 8'h00);
  endtask

  task automatic test_runt();
    logic [17:0] pkt; logic fok, got, rdy; logic [7:0] d; logic [2:0] st; int lat, early; time ta;
    send_cmd(1'b1, 8'h01, 8'h00, pkt, fok, ta);
    #(CPB/2*PER);
    @(negedge clk); piso = 1'b0;
    repeat (5) @(negedge clk);
    piso = 1'b1;
    early = 0;
    repeat (2*CPB) begin @(negedge clk); if (rsp_valid === 1'b1) early++; end
    checks++;
    if (early != 0) begin errors++; $display("FAIL runt_no_rsp got %0d pulses want 0", early); end
    send_reply(model_pkt(1'b1, 8'h01, mem[8'h01]), 1'b1, got, d, st, lat, rdy);
    checks++;
    if (!got || st !== 3'd0 || d !== mem[8'h01]) begin
      errors++; $display("FAIL runt_then_valid got %b status %0d data %h want 1 0 %h", got, st, d, mem[8'h01]);
    end
  endtask

  task automatic test_no_reply();
    logic [17:0] pkt; logic fok; time ta;
`ifdef UART_HOST_TIMEOUT_EN
    logic got, rdy; logic [7:0] d; logic [2:0] st; int lat;
    send_cmd(1'b1, 8'h05, 8'h00, pkt, fok, ta);
    wait_rsp((TOB + 4)*CPB, ta, got, d, st, lat, rdy);
    checks++;
    if (!got || st !== 3'd4 || d !== 8'h00 || lat !== (20 + TOB)*CPB + 1) begin
      errors++; $display("FAIL timeout got %b status %0d data %h lat %0d want 1 4 00 %0d", got, st, d, lat, (20 + TOB)*CPB + 1);
    end
`else
    int pulses;
    send_cmd(1'b1, 8'h05, 8'h00, pkt, fok, ta);
    pulses = 0;
    repeat ((TOB + 6)*CPB) begin @(negedge clk); if (rsp_valid === 1'b1) pulses++; end
    checks++;
    if (pulses != 0 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL no_reply_wait pulses %0d ready %b want 0 0", pulses, cmd_ready);
    end
    do_reset();
`endif
  endtask

  task automatic test_reset_mid();
    int pulses, hi_err;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wrb = 1'b0; cmd_addr = 8'h33; cmd_data = 8'h00;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (5*CPB) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (posi !== 1'b1)      begin errors++; $display("FAIL midreset_posi got %b want 1", posi); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b want 1", cmd_ready); end
    reset = 1'b0;
    pulses = 0; hi_err = 0;
    repeat (25*CPB) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) pulses++;
      if (posi !== 1'b1) hi_err++;
    end
    checks++;
    if (pulses != 0 || hi_err != 0) begin errors++; $display("FAIL midreset_quiet pulses %0d posi_low %0d want 0 0", pulses, hi_err); end
  endtask

  task automatic test_random();
    logic [7:0] a, dt;
    for (int n = 0; n < 100; n++) begin
      a = 8'($urandom_range(0, 15));
      dt = 8'($urandom);
      if ($urandom_range(0, 1) == 0) do_write("rnd_wr", a, dt, 1'b0);
      else do_read("rnd_rd", a, model_pkt(1'b1, a, mem[a]), 1'b1, 3'd0, mem[a]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_errors();
    test_runt();
    test_no_reply();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
